// File: rtl/program_loader.sv
// program_loader: writer side of the CPU instruction store.
// Receives a framed byte stream (HEADER, N, N x 4 data bytes, checksum),
// assembles 28-bit instruction words and writes them to the instruction RAM
// at consecutive addresses starting at 0. Holds the CPU in reset while a
// load is in progress or has failed, and reports completion or an error code.
//
// Ports:
//   Clock          in   system clock, rising edge
//   Reset          in   asynchronous, active-high reset
//   iStart         in   one-cycle pulse arming the loader (IDLE/DONE/ERROR only)
//   iByte          in   received byte
//   iByteValid     in   iByte valid strobe, one cycle per byte
//   oWriteEnable   out  one-cycle RAM write strobe
//   oWriteAddress  out  RAM write address
//   oWriteData     out  RAM write data (28-bit instruction)
//   oCpuHold       out  holds the CPU in reset while high
//   oDone          out  load completed with good checksum (level)
//   oError         out  00 none, 01 zero count, 10 bad nibble, 11 checksum
//   oWordCount     out  words written in the current load
module program_loader #(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          INSTR_WIDTH = 28,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oWriteData,
  output logic                   oCpuHold,
  output logic                   oDone,
  output logic [1:0]             oError,
  output logic [ADDR_WIDTH-1:0]  oWordCount
);

  typedef enum logic [2:0] {
    IDLE, WAIT_HDR, GET_COUNT, GET_DATA, GET_CSUM, DONE, ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;    // byte index within current word
  logic [7:0]               cnt_q, cnt_d;    // word count N
  logic [7:0]               csum_q, csum_d;  // modulo-256 sum of data bytes
  logic [19:0]              asm_q, asm_d;    // word bits [27:8] collected so far

  logic                     we_d;
  logic [ADDR_WIDTH-1:0]    waddr_d;
  logic [INSTR_WIDTH-1:0]   wdata_d;
  logic                     hold_d;
  logic                     done_d;
  logic [1:0]               err_d;
  logic [ADDR_WIDTH-1:0]    wc_d;
  logic [ADDR_WIDTH-1:0]    wc_next;

  assign wc_next = oWordCount + ADDR_WIDTH'(1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      csum_q        <= '0;
      asm_q         <= '0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oCpuHold      <= 1'b0;
      oDone         <= 1'b0;
      oError        <= '0;
      oWordCount    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      asm_q         <= asm_d;
      oWriteEnable  <= we_d;
      oWriteAddress <= waddr_d;
      oWriteData    <= wdata_d;
      oCpuHold      <= hold_d;
      oDone         <= done_d;
      oError        <= err_d;
      oWordCount    <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = oWriteAddress;
    wdata_d = oWriteData;
    hold_d  = oCpuHold;
    done_d  = oDone;
    err_d   = oError;
    wc_d    = oWordCount;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (iStart) begin
          state_d = WAIT_HDR;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 2'b00;
          wc_d    = '0;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      WAIT_HDR: begin
        if (iByteValid && iByte == HEADER) state_d = GET_COUNT;
      end
      GET_COUNT: begin
        if (iByteValid) begin
          if (iByte == 8'd0) begin
            state_d = ERROR;
            err_d   = 2'b01;
          end else begin
            cnt_d   = iByte;
            state_d = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (iByteValid) begin
          csum_d = csum_q + iByte;
          idx_d  = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: begin
              if (iByte[7:4] != 4'd0) begin
                state_d = ERROR;
                err_d   = 2'b10;
              end else begin
                asm_d[19:16] = iByte[3:0];
              end
            end
            2'd1: asm_d[15:8] = iByte;
            2'd2: asm_d[7:0]  = iByte;
            default: begin
              // Final byte: strobe and count update land together on the
              // next edge, so address takes the pre-increment count.
              we_d    = 1'b1;
              wdata_d = INSTR_WIDTH'({asm_q, iByte});
              waddr_d = oWordCount;
              wc_d    = wc_next;
              if (wc_next == ADDR_WIDTH'(cnt_q)) state_d = GET_CSUM;
            end
          endcase
        end
      end
      GET_CSUM: begin
        if (iByteValid) begin
          if (iByte == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 2'b11;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the test plan
// plus randomized frames, each compared against a frame-level reference model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        we;
  logic [15:0] waddr;
  logic [27:0] wdata;
  logic        hold;
  logic        done;
  logic [1:0]  err;
  logic [15:0] wcount;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [43:0] wr_q[$];   // observed writes {addr, data}

  program_loader #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .HEADER(8'hA5)) dut (
    .Clock(clk), .Reset(rst), .iStart(start), .iByte(byte_in),
    .iByteValid(byte_valid), .oWriteEnable(we), .oWriteAddress(waddr),
    .oWriteData(wdata), .oCpuHold(hold), .oDone(done), .oError(err),
    .oWordCount(wcount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (we) wr_q.push_back({waddr, wdata});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends bytes; with gaps=0 every byte is on a consecutive cycle.
  task automatic send(input logic [7:0] q[$], input bit gaps);
    foreach (q[i]) begin
      byte_in    = q[i];
      byte_valid = 1'b1;
      tick();
      if (gaps && ($urandom % 3 == 0)) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
    end
    byte_valid = 1'b0;
  endtask

  // Frame-level model: expected writes and final status after iStart + bytes.
  task automatic model(input logic [7:0] q[$], output logic [43:0] exp_w[$],
                       output logic [1:0] e_err, output bit e_done, output bit e_hold);
    int unsigned i = 0;
    int unsigned n;
    int unsigned sum = 0;
    exp_w.delete();
    e_err = 2'b00; e_done = 0; e_hold = 1;
    while (i < q.size() && q[i] != 8'hA5) i++;
    if (i + 1 >= q.size()) return;
    n = q[i+1];
    i += 2;
    if (n == 0) begin e_err = 2'b01; return; end
    for (int unsigned w = 0; w < n; w++) begin
      if (i + 4 > q.size()) return;
      if (q[i][7:4] != 4'd0) begin e_err = 2'b10; return; end
      exp_w.push_back({16'(w), q[i][3:0], q[i+1], q[i+2], q[i+3]});
      sum += q[i] + q[i+1] + q[i+2] + q[i+3];
      i += 4;
    end
    if (i >= q.size()) return;
    if (q[i] == 8'(sum % 256)) begin e_done = 1; e_hold = 0; end
    else e_err = 2'b11;
  endtask

  task automatic run_frame(input string name, input logic [7:0] q[$], input bit gaps);
    logic [43:0] exp_w[$];
    logic [1:0]  e_err;
    bit          e_done, e_hold;
    model(q, exp_w, e_err, e_done, e_hold);
    wr_q.delete();
    pulse_start();
    send(q, gaps);
    repeat (3) tick();
    check({name, " nwrites"}, 44'(wr_q.size()), 44'(exp_w.size()));
    for (int unsigned k = 0; k < exp_w.size() && k < wr_q.size(); k++)
      check($sformatf("%s write%0d", name, k), wr_q[k], exp_w[k]);
    check({name, " done"}, 44'(done), 44'(e_done));
    check({name, " error"}, 44'(err), 44'(e_err));
    check({name, " hold"}, 44'(hold), 44'(e_hold));
    check({name, " wordcount"}, 44'(wcount), 44'(exp_w.size()));
  endtask

  task automatic check_zero(input string name);
    check({name, " we"}, 44'(we), 44'd0);
    check({name, " addr"}, 44'(waddr), 44'd0);
    check({name, " data"}, 44'(wdata), 44'd0);
    check({name, " hold"}, 44'(hold), 44'd0);
    check({name, " done"}, 44'(done), 44'd0);
    check({name, " error"}, 44'(err), 44'd0);
    check({name, " wordcount"}, 44'(wcount), 44'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    rst = 1'b1; start = 1'b0; byte_in = '0; byte_valid = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Write latency: strobe one cycle after the 4th byte, exactly one cycle long.
    wr_q.delete();
    pulse_start();
    send('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10}, 0);
    byte_in = 8'hF0; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    check("latency we", 44'(we), 44'd1);
    check("latency addr", 44'(waddr), 44'd0);
    check("latency data", 44'(wdata), 44'h00010F0);
    tick();
    check("strobe width", 44'(we), 44'd0);
    send('{8'h00}, 0);
    tick();
    check("tp1 done", 44'(done), 44'd1);
    check("tp1 hold", 44'(hold), 44'd0);
    check("tp1 wordcount", 44'(wcount), 44'd1);

    run_frame("tp1", '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10, 8'hF0, 8'h00}, 0);
    run_frame("tp2", '{8'h3C, 8'h77, 8'hA5, 8'h02, 8'h08, 8'h00, 8'h00, 8'h20,
                       8'h0B, 8'h40, 8'h00, 8'h00, 8'h73}, 0);
    run_frame("tp3", '{8'hA5, 8'h01, 8'h1F, 8'h00, 8'h00, 8'h00}, 0);
    run_frame("tp4", '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h06}, 0);
    run_frame("tp5", '{8'hA5, 8'h00}, 0);
    pulse_start();
    check("rearm error", 44'(err), 44'd0);
    check("rearm hold", 44'(hold), 44'd1);
    run_frame("rearm", '{8'hA5, 8'h01, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0);

    // Randomized frames.
    for (int unsigned t = 0; t < 40; t++) begin
      int unsigned n;
      int unsigned sum;
      q.delete();
      sum = 0;
      repeat ($urandom_range(0, 2)) q.push_back(8'($urandom_range(0, 8'hA4)));
      n = $urandom_range(1, 6);
      q.push_back(8'hA5);
      q.push_back(8'(n));
      for (int unsigned w = 0; w < n; w++) begin
        for (int unsigned b = 0; b < 4; b++) begin
          logic [7:0] v;
          v = 8'($urandom);
          if (b == 0 && ($urandom % 25 != 0)) v[7:4] = 4'd0;
          q.push_back(v);
          sum += v;
        end
      end
      q.push_back(($urandom % 5 == 0) ? 8'(sum + 1) : 8'(sum));
      run_frame($sformatf("rand%0d", t), q, bit'($urandom % 2));
    end

    // Reset in the middle of GET_DATA.
    pulse_start();
    send('{8'hA5, 8'h02, 8'h01, 8'h02}, 0);
    #2 rst = 1'b1;
    #1 check_zero("midreset");
    tick();
    rst = 1'b0;
    wr_q.delete();
    send('{8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    repeat (3) tick();
    check("midreset nwrites", 44'(wr_q.size()), 44'd0);
    check("midreset hold after", 44'(hold), 44'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
